counter_mod: RTL and testbench

Parametrised modulo counter with up/down counting, wrap or saturate mode, programmable limit, load, and a self-timed one-shot countdown with done pulse. Successor to the fixed-width up-counter used to count dclk cycles. The sequencing FSM issues opcodes, and a tick enable (e.g. a dclk edge strobe) gates counting. One-shot mode lets the controller start a burst of N ticks and wait for `done_o` instead of polling the count.

---
 rtl/counter_mod.sv | 130 +++++++++++++
 tb/tb_counter_mod.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/counter_mod.sv
// rtl/counter_mod.sv - modulo up/down counter with limit, load and one-shot countdown
module counter_mod #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [2:0]       opc_i,
  input  logic             mode_i,
  input  logic [Width-1:0] ld_i,
  output logic [Width-1:0] cnt_o,
  output logic [Width-1:0] lim_o,
  output logic             zero_o,
  output logic             max_o,
  output logic             wrap_o,
  output logic             done_o,
  output logic             busy_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [2:0] OpHold  = 3'b000;
  localparam logic [2:0] OpUp    = 3'b001;
  localparam logic [2:0] OpDown  = 3'b010;
  localparam logic [2:0] OpLoad  = 3'b011;
  localparam logic [2:0] OpLimit = 3'b100;
  localparam logic [2:0] OpClear = 3'b101;
  localparam logic [2:0] OpStart = 3'b110;
  localparam logic [2:0] OpAbort = 3'b111;

  localparam logic [Width-1:0] One  = {{(Width-1){1'b0}}, 1'b1};
  localparam logic [Width-1:0] Zero = '0;

  state_e           state_q, state_d;
  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] lim_q, lim_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  // Next-state: IDLE decodes every opcode; RUN only counts down or honours abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    if (state_q == ST_RUN) begin
      if (opc_i == OpAbort) begin
        cnt_d   = Zero;
        state_d = ST_IDLE;
      end else if (en_i) begin
        cnt_d = cnt_q - One;
        if (cnt_q == One) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end else begin
      case (opc_i)
        OpHold: begin
        end
        OpUp: begin
          if (en_i) begin
            if (cnt_q < lim_q) begin
              cnt_d = cnt_q + One;
            end else if (mode_i) begin
              cnt_d = lim_q;
            end else begin
              cnt_d  = Zero;
              wrap_d = 1'b1;
            end
          end
        end
        OpDown: begin
          if (en_i) begin
            if (cnt_q != Zero) begin
              cnt_d = cnt_q - One;
            end else if (!mode_i) begin
              cnt_d  = lim_q;
              wrap_d = 1'b1;
            end
          end
        end
        OpLoad:  cnt_d = ld_i;
        OpLimit: lim_d = ld_i;
        OpClear: cnt_d = Zero;
        OpStart: begin
          cnt_d = lim_q;
          if (lim_q != Zero) begin
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
        OpAbort: cnt_d = Zero;
        default: begin
        end
      endcase
    end
  end

  // State and output registers; reset overrides every input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= Zero;
      lim_q   <= '1;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign lim_o  = lim_q;
  assign zero_o = (cnt_q == Zero);
  assign max_o  = (cnt_q >= lim_q);
  assign wrap_o = wrap_q;
  assign done_o = done_q;
  assign busy_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_mod.sv
// tb/tb_counter_mod.sv - self-checking bench for counter_mod
module tb_counter_mod;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst, en, mode;
  logic [2:0]   opc;
  logic [W-1:0] ld;
  logic [W-1:0] cnt_o, lim_o;
  logic         zero_o, max_o, wrap_o, done_o, busy_o;

  counter_mod #(.Width(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en),
    .opc_i (opc),
    .mode_i(mode),
    .ld_i  (ld),
    .cnt_o (cnt_o),
    .lim_o (lim_o),
    .zero_o(zero_o),
    .max_o (max_o),
    .wrap_o(wrap_o),
    .done_o(done_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: count and limit as plain integers, plus "ticks remaining" view of RUN.
  int m_cnt  = 0;
  int m_lim  = M - 1;
  bit m_run  = 0;
  bit m_wrap = 0;
  bit m_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    m_wrap = 0;
    m_done = 0;
    if (rst) begin
      m_cnt = 0; m_lim = M - 1; m_run = 0;
    end else if (m_run) begin
      if (opc == 3'd7) begin
        m_cnt = 0; m_run = 0;
      end else if (en) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_run = 0; m_done = 1; end
      end
    end else begin
      case (opc)
        3'd1: if (en) begin
          if (m_cnt < m_lim) m_cnt = (m_cnt + 1) % M;
          else if (mode) m_cnt = m_lim;
          else begin m_cnt = 0; m_wrap = 1; end
        end
        3'd2: if (en) begin
          if (m_cnt > 0) m_cnt = m_cnt - 1;
          else if (!mode) begin m_cnt = m_lim; m_wrap = 1; end
        end
        3'd3: m_cnt = int'(ld);
        3'd4: m_lim = int'(ld);
        3'd5: m_cnt = 0;
        3'd6: begin
          m_cnt = m_lim;
          if (m_lim > 0) m_run = 1; else m_done = 1;
        end
        3'd7: m_cnt = 0;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cnt",  32'(cnt_o),  32'(m_cnt));
    check("lim",  32'(lim_o),  32'(m_lim));
    check("zero", 32'(zero_o), 32'(m_cnt == 0));
    check("max",  32'(max_o),  32'(m_cnt >= m_lim));
    check("wrap", 32'(wrap_o), 32'(m_wrap));
    check("done", 32'(done_o), 32'(m_done));
    check("busy", 32'(busy_o), 32'(m_run));
  endtask

  task automatic drive(input bit r, input bit e, input bit md, input logic [2:0] o, input logic [W-1:0] l);
    rst = r; en = e; mode = md; opc = o; ld = l;
  endtask

  int seq_up[7]  = '{1, 2, 3, 4, 5, 0, 1};
  int seq_dn[4]  = '{1, 0, 0, 0};
  int en_edges, dones, budget;

  initial begin
    drive(1, 0, 0, 3'd0, '0);
    tick(); tick();
    check("rst_cnt",  32'(cnt_o),  32'h0);
    check("rst_lim",  32'(lim_o),  32'hFF);
    check("rst_zero", 32'(zero_o), 32'h1);
    check("rst_busy", 32'(busy_o), 32'h0);

    // Wrap at limit 5
    drive(0, 1, 0, 3'd4, 8'd5); tick();
    drive(0, 1, 0, 3'd1, 8'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("up_seq",  32'(cnt_o),  32'(seq_up[i]));
      check("up_wrap", 32'(wrap_o), 32'(i == 5));
    end

    // Saturate down, then load above limit and saturate up
    drive(0, 1, 1, 3'd3, 8'd2); tick();
    drive(0, 1, 1, 3'd2, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sat_dn",   32'(cnt_o),  32'(seq_dn[i]));
      check("sat_wrap", 32'(wrap_o), 32'h0);
    end
    drive(0, 1, 1, 3'd4, 8'd3); tick();
    drive(0, 1, 1, 3'd3, 8'd7); tick();
    check("ld_above", 32'(cnt_o), 32'h7);
    drive(0, 1, 1, 3'd1, 8'd0); tick();
    check("sat_up", 32'(cnt_o), 32'h3);

    // One-shot of 25 with en toggling; stray opcodes in RUN ignored
    drive(0, 0, 0, 3'd4, 8'd25); tick();
    drive(0, 0, 0, 3'd6, 8'd99); tick();
    check("os_busy0", 32'(busy_o), 32'h1);
    check("os_cnt0",  32'(cnt_o),  32'd25);
    en_edges = 0; dones = 0; budget = 0;
    while (busy_o && budget < 200) begin
      drive(0, (budget % 2) == 0, $urandom_range(0, 1), (budget % 3 == 0) ? 3'd1 : 3'd3, 8'($urandom));
      if (en) en_edges++;
      tick();
      if (done_o) dones++;
      budget++;
    end
    check("os_timeout", 32'(budget < 200), 32'h1);
    check("os_edges",   32'(en_edges), 32'd25);
    check("os_dones",   32'(dones),    32'd1);
    check("os_cnt_end", 32'(cnt_o),    32'h0);

    // Limit 0 start: immediate done, never busy
    drive(0, 1, 0, 3'd4, 8'd0); tick();
    drive(0, 1, 0, 3'd6, 8'd0); tick();
    check("l0_done", 32'(done_o), 32'h1);
    check("l0_busy", 32'(busy_o), 32'h0);
    drive(0, 1, 0, 3'd0, 8'd0); tick();
    check("l0_pulse", 32'(done_o), 32'h0);

    // Abort and reset at cnt=4
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 3'd4, 8'd10); tick();
      drive(0, 1, 0, 3'd6, 8'd0); tick();
      drive(0, 1, 0, 3'd0, 8'd0);
      for (int i = 0; i < 6; i++) tick();
      check("ab_at4", 32'(cnt_o), 32'd4);
      if (k == 0) drive(0, 1, 0, 3'd7, 8'd0);
      else drive(1, 1, 0, 3'd0, 8'd0);
      tick();
      check("ab_cnt",  32'(cnt_o),  32'h0);
      check("ab_busy", 32'(busy_o), 32'h0);
      check("ab_done", 32'(done_o), 32'h0);
    end

    // Random traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 6)) : 8'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
